cobra_run_ctrl: RTL

Run-control sequencer for the CYBERcobra single-cycle core. It gates PC advance and register-file write enable, so the core can be halted, single-stepped, run freely or stopped on a PC breakpoint. It also arbitrates RF read port 1 between the core and a debug requester. It sits between the top level and the core datapath.

---
 rtl/cobra_run_ctrl_pkg.sv | 9 +
 rtl/cobra_run_ctrl_if.sv | 13 +
 rtl/cobra_run_ctrl_bp_unit.sv | 31 +++
 rtl/cobra_run_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/cobra_run_ctrl_pkg.sv
// Shared types and widths for the CYBERcobra run-control block.
package cobra_pkg;

    typedef enum logic [1:0] {HALT, RUN, STEP, DBG} run_state_t;

    localparam int unsigned RF_ADDR_W = 5;
    localparam int unsigned RF_DATA_W = 32;

endpackage

// File: rtl/cobra_run_ctrl_if.sv
// Debug RF read channel: level request with address in, one-cycle ack with captured data out.
interface cobra_run_ctrl_if;
    import cobra_pkg::*;

    logic                 req;
    logic [RF_ADDR_W-1:0] addr;
    logic                 ack;
    logic [RF_DATA_W-1:0] data;

    modport master (output req, output addr, input ack, input data);
    modport slave  (input req, input addr, output ack, output data);

endinterface

// File: rtl/cobra_run_ctrl_bp_unit.sv
// PC breakpoint comparator with a one-shot skip so a resumed run can leave the breakpoint PC.
module cobra_bp_unit
    import cobra_pkg::*;
#(
    parameter int unsigned PC_W = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_run_i,
    input  logic            set_skip_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic            bp_en_i,
    input  logic [PC_W-1:0] bp_addr_i,
    output logic            bp_trip_o
);

    logic skip_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            skip_q <= 1'b0;
        end else if (set_skip_i) begin
            skip_q <= 1'b1;
        end else if (in_run_i) begin
            skip_q <= 1'b0;
        end
    end

    assign bp_trip_o = in_run_i & bp_en_i & (pc_i == bp_addr_i) & ~skip_q;

endmodule

// File: rtl/cobra_run_ctrl.sv
// Run-control sequencer for the CYBERcobra core: halt, single-step, free-run and debug RF reads.
// The PC breakpoint is built only when COBRA_RUN_CTRL_BP_EN is defined.
module cobra_run_ctrl
    import cobra_pkg::*;
#(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 run_i,
    input  logic                 halt_i,
    input  logic                 step_i,
    input  logic [PC_W-1:0]      pc_i,
    input  logic                 bp_en_i,
    input  logic [PC_W-1:0]      bp_addr_i,
    cobra_run_ctrl_if.slave      dbg,
    input  logic [RF_DATA_W-1:0] rf_rd1_i,
    output logic                 pc_en_o,
    output logic                 rf_we_en_o,
    output logic                 ra1_sel_o,
    output logic [RF_ADDR_W-1:0] dbg_addr_o,
    output logic                 halted_o,
    output logic                 bp_hit_o,
    output logic [CNT_W-1:0]     retired_o
);

    run_state_t           state_q, state_d, ret_q, ret_d;
    logic                 bp_hit_q, bp_hit_d;
    logic                 ack_q;
    logic [RF_DATA_W-1:0] data_q;
    logic [RF_ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]     retired_q;
    logic                 set_skip, bp_trip, dbg_go, pc_en;

    // Masking with ack lets a held request restart one cycle after its ack.
    assign dbg_go = dbg.req & ~ack_q;

`ifdef COBRA_RUN_CTRL_BP_EN
    cobra_bp_unit #(
        .PC_W(PC_W)
    ) u_bp (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_run_i  (state_q == RUN),
        .set_skip_i(set_skip),
        .pc_i      (pc_i),
        .bp_en_i   (bp_en_i),
        .bp_addr_i (bp_addr_i),
        .bp_trip_o (bp_trip)
    );
`else
    logic unused_bp;
    assign unused_bp = ^{bp_en_i, bp_addr_i, pc_i, set_skip};
    assign bp_trip   = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        bp_hit_d = bp_hit_q;
        set_skip = 1'b0;
        pc_en    = 1'b0;
        unique case (state_q)
            HALT: begin
                if (!halt_i) begin
                    if (dbg_go) begin
                        state_d = DBG;
                        ret_d   = HALT;
                    end else if (step_i) begin
                        state_d  = STEP;
                        bp_hit_d = 1'b0;
                    end else if (run_i) begin
                        state_d  = RUN;
                        set_skip = 1'b1;
                        bp_hit_d = 1'b0;
                    end
                end
            end
            RUN: begin
                // The breakpointed instruction must not commit.
                pc_en = ~bp_trip;
                if (halt_i) begin
                    state_d = HALT;
                end else if (bp_trip) begin
                    state_d  = HALT;
                    bp_hit_d = 1'b1;
                end else if (dbg_go) begin
                    state_d = DBG;
                    ret_d   = RUN;
                end
            end
            STEP: begin
                pc_en   = 1'b1;
                state_d = HALT;
            end
            DBG: begin
                if (halt_i) begin
                    ret_d   = HALT;
                    state_d = HALT;
                end else begin
                    state_d = ret_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= HALT;
            ret_q     <= HALT;
            bp_hit_q  <= 1'b0;
            ack_q     <= 1'b0;
            data_q    <= '0;
            addr_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            bp_hit_q <= bp_hit_d;
            ack_q    <= (state_q == DBG);
            if (state_q == DBG) begin
                data_q <= rf_rd1_i;
            end
            if (state_d == DBG) begin
                addr_q <= dbg.addr;
            end
            if (pc_en) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign pc_en_o    = pc_en;
    assign rf_we_en_o = pc_en;
    assign ra1_sel_o  = (state_q == DBG);
    assign halted_o   = (state_q == HALT);
    assign bp_hit_o   = bp_hit_q;
    assign dbg_addr_o = addr_q;
    assign retired_o  = retired_q;
    assign dbg.ack    = ack_q;
    assign dbg.data   = data_q;

endmodule
